cisr_row_decoder: RTL and testbench

Per-channel CISR row decoder for the SpMV datapath. It sits between the fetch/arbiter stage and the multiply channel. It consumes one matrix slot per channel per cycle together with that slot's row-length word. It allocates global row IDs to channels in CISR order and emits, per channel, the row ID of each element plus a last-element flag. The multiply channel carries these to the accumulator.

---
 rtl/cisr_row_decoder.sv | 165 ++++++++++++++++
 tb/tb_cisr_row_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cisr_row_decoder.sv
`default_nettype none
// cisr_row_decoder: per-channel CISR row-ID allocation and tagging for the SpMV multiply lanes.
// Optional checking: define CISR_DEC_ERRCHK_EN to build the sticky err flag (zero-length rows, overflow).
module cisr_row_decoder #(
  parameter int SPM_ELE_W = 32,
  parameter int CHAN_NUM  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SPM_ELE_W-1:0] num_rows,
  input  logic                 stall,
  input  logic [CHAN_NUM-1:0]  slot_valid,
  input  logic [SPM_ELE_W-1:0] row_len_in [CHAN_NUM],
  output logic [SPM_ELE_W-1:0] row_id_out [CHAN_NUM],
  output logic [CHAN_NUM-1:0]  row_id_valid,
  output logic [CHAN_NUM-1:0]  row_last,
  output logic [CHAN_NUM-1:0]  row_start,
  output logic                 done,
  output logic                 err
);

  typedef logic [SPM_ELE_W-1:0] word_t;
  typedef logic [SPM_ELE_W:0]   wide_t;

  localparam word_t ONE_W = word_t'(1);
  localparam wide_t ONE_X = wide_t'(1);

  word_t               rem_q    [CHAN_NUM];
  word_t               rem_d    [CHAN_NUM];
  word_t               cur_id_q [CHAN_NUM];
  word_t               cur_id_d [CHAN_NUM];
  word_t               row_id_q [CHAN_NUM];
  word_t               row_id_d [CHAN_NUM];
  word_t               next_row_q, next_row_d;
  word_t               num_rows_q, num_rows_d;
  logic [CHAN_NUM-1:0] valid_q, valid_d;
  logic [CHAN_NUM-1:0] last_q, last_d;
  logic [CHAN_NUM-1:0] start_q, start_d;
  logic                done_q, done_d;

  wide_t               alloc_id;
  wide_t               start_cnt;
  word_t               acc_cnt;
  logic                all_idle;
`ifdef CISR_DEC_ERRCHK_EN
  logic                zero_len_hit;
  logic                overflow_hit;
`endif

  always_comb begin
    next_row_d = next_row_q;
    num_rows_d = num_rows_q;
    done_d     = done_q;
    valid_d    = '0;
    last_d     = '0;
    start_d    = '0;
    alloc_id   = '0;
    start_cnt  = '0;
    acc_cnt    = '0;
    all_idle   = 1'b1;
`ifdef CISR_DEC_ERRCHK_EN
    zero_len_hit = 1'b0;
    overflow_hit = 1'b0;
`endif
    for (int i = 0; i < CHAN_NUM; i++) begin
      rem_d[i]    = rem_q[i];
      cur_id_d[i] = cur_id_q[i];
      row_id_d[i] = row_id_q[i];
      if (rem_q[i] != '0) all_idle = 1'b0;
    end

    if (start) begin
      next_row_d = '0;
      num_rows_d = num_rows;
      done_d     = 1'b0;
      for (int i = 0; i < CHAN_NUM; i++) begin
        rem_d[i]    = '0;
        cur_id_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < CHAN_NUM; i++) begin
        if (slot_valid[i]) begin
          if (rem_q[i] == '0) begin
            // Ranks by every lower starter; once one overflows all higher ones do too.
            alloc_id  = {1'b0, next_row_q} + start_cnt;
            start_cnt = start_cnt + ONE_X;
            if (alloc_id < {1'b0, num_rows_q}) begin
              acc_cnt     = acc_cnt + ONE_W;
              cur_id_d[i] = alloc_id[SPM_ELE_W-1:0];
              row_id_d[i] = alloc_id[SPM_ELE_W-1:0];
              rem_d[i]    = (row_len_in[i] == '0) ? '0 : row_len_in[i] - ONE_W;
              valid_d[i]  = 1'b1;
              start_d[i]  = 1'b1;
              last_d[i]   = (row_len_in[i] <= ONE_W);
`ifdef CISR_DEC_ERRCHK_EN
              if (row_len_in[i] == '0) zero_len_hit = 1'b1;
            end else begin
              overflow_hit = 1'b1;
`endif
            end
          end else begin
            row_id_d[i] = cur_id_q[i];
            rem_d[i]    = rem_q[i] - ONE_W;
            valid_d[i]  = 1'b1;
            last_d[i]   = (rem_q[i] == ONE_W);
          end
        end
      end
      // Accepted ids are all below num_rows_q, so this never passes it.
      next_row_d = next_row_q + acc_cnt;
      done_d     = done_q | ((next_row_q >= num_rows_q) && all_idle);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q      <= '{default: '0};
      cur_id_q   <= '{default: '0};
      row_id_q   <= '{default: '0};
      next_row_q <= '0;
      num_rows_q <= '0;
      valid_q    <= '0;
      last_q     <= '0;
      start_q    <= '0;
      done_q     <= 1'b0;
    end else if (start || !stall) begin
      rem_q      <= rem_d;
      cur_id_q   <= cur_id_d;
      row_id_q   <= row_id_d;
      next_row_q <= next_row_d;
      num_rows_q <= num_rows_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      start_q    <= start_d;
      done_q     <= done_d;
    end
  end

`ifdef CISR_DEC_ERRCHK_EN
  logic err_q, err_d;

  assign err_d = start ? 1'b0 : (err_q | zero_len_hit | overflow_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start || !stall) begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign row_id_out   = row_id_q;
  assign row_id_valid = valid_q;
  assign row_last     = last_q;
  assign row_start    = start_q;
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cisr_row_decoder.sv
`default_nettype none
// tb_cisr_row_decoder: directed and randomized checks against a cycle-level behavioural model.
module tb_cisr_row_decoder;

  localparam int W = 32;
  localparam int N = 16;
`ifdef CISR_DEC_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] num_rows;
  logic         stall;
  logic [N-1:0] slot_valid;
  logic [W-1:0] row_len_in [N];
  logic [W-1:0] row_id_out [N];
  logic [N-1:0] row_id_valid, row_last, row_start;
  logic         done, err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  longint       m_rem [N];
  longint       m_cur [N];
  longint       m_next, m_num;
  bit           m_done, m_err;
  logic [N-1:0] e_valid, e_last, e_start;
  logic [W-1:0] e_id [N];

  cisr_row_decoder #(.SPM_ELE_W(W), .CHAN_NUM(N)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .stall(stall),
    .slot_valid(slot_valid), .row_len_in(row_len_in), .row_id_out(row_id_out),
    .row_id_valid(row_id_valid), .row_last(row_last), .row_start(row_start),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_rem[c] = 0; m_cur[c] = 0; e_id[c] = '0;
    end
    m_next = 0; m_num = 0; m_done = 0; m_err = 0;
    e_valid = '0; e_last = '0; e_start = '0;
  endtask

  // Evaluates the rules for one clock edge from the inputs currently applied.
  task automatic model_step();
    bit     idle;
    bit     ev;
    longint base, id, len;
    int     starters;
    if (start) begin
      for (int c = 0; c < N; c++) begin m_rem[c] = 0; m_cur[c] = 0; end
      m_next = 0; m_num = longint'(num_rows); m_done = 0; m_err = 0;
      e_valid = '0; e_last = '0; e_start = '0;
    end else if (!stall) begin
      idle = 1;
      for (int c = 0; c < N; c++) if (m_rem[c] != 0) idle = 0;
      if (m_next >= m_num && idle) m_done = 1;
      base = m_next; starters = 0; ev = 0;
      e_valid = '0; e_last = '0; e_start = '0;
      for (int c = 0; c < N; c++) begin
        if (!slot_valid[c]) continue;
        if (m_rem[c] == 0) begin
          id = base + starters;
          starters++;
          if (id < m_num) begin
            len = longint'(row_len_in[c]);
            if (len == 0) begin ev = 1; len = 1; end
            m_cur[c] = id; m_rem[c] = len - 1; m_next++;
            e_id[c] = W'(id); e_valid[c] = 1; e_start[c] = 1; e_last[c] = (len == 1);
          end else begin
            ev = 1;
          end
        end else begin
          e_id[c] = W'(m_cur[c]); e_valid[c] = 1; e_last[c] = (m_rem[c] == 1);
          m_rem[c]--;
        end
      end
      if (ERRCHK && ev) m_err = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    start = 0; stall = 0; slot_valid = '0;
    for (int c = 0; c < N; c++) row_len_in[c] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle(); num_rows = '0;
    model_reset();
    #12;
    checks++;
    if (row_id_valid !== '0 || row_last !== '0 || row_start !== '0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got valid=%h last=%h start=%h done=%b err=%b exp all 0",
               row_id_valid, row_last, row_start, done, err);
    end
    for (int c = 0; c < N; c++) begin
      checks++;
      if (row_id_out[c] !== '0) begin
        failures++;
        $display("FAIL reset_id ch=%0d got %0d exp 0", c, row_id_out[c]);
      end
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit v0 [4]  = '{1, 1, 1, 0};
    int l0 [4]  = '{2, 9, 1, 9};
    int l1 [4]  = '{3, 9, 9, 1};
    int id0 [3] = '{0, 0, 2};
    int id1 [4] = '{1, 1, 1, 3};
    bit ls0 [3] = '{0, 1, 1};
    bit ls1 [4] = '{0, 0, 1, 1};
    int n0 = 0, n1 = 0;
    drive_idle(); start = 1; num_rows = 4; tick(); start = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      slot_valid = '0; slot_valid[0] = v0[cyc]; slot_valid[1] = 1'b1;
      row_len_in[0] = l0[cyc]; row_len_in[1] = l1[cyc];
      tick();
      checks++;
      if (row_id_valid !== e_valid || row_last !== e_last || row_start !== e_start || done !== m_done) begin
        failures++;
        $display("FAIL basic_model cyc=%0d got v=%h l=%h s=%h d=%b exp v=%h l=%h s=%h d=%b", cyc,
                 row_id_valid, row_last, row_start, done, e_valid, e_last, e_start, m_done);
      end
      if (row_id_valid[0]) begin
        checks++;
        if (n0 >= 3 || row_id_out[0] !== W'(id0[n0]) || row_last[0] !== ls0[n0]) begin
          failures++;
          $display("FAIL basic_ch0 beat=%0d got id=%0d last=%b exp id=%0d last=%b", n0,
                   row_id_out[0], row_last[0], (n0 < 3) ? id0[n0] : -1, (n0 < 3) ? ls0[n0] : 1'b0);
        end
        n0++;
      end
      if (row_id_valid[1]) begin
        checks++;
        if (n1 >= 4 || row_id_out[1] !== W'(id1[n1]) || row_last[1] !== ls1[n1]) begin
          failures++;
          $display("FAIL basic_ch1 beat=%0d got id=%0d last=%b exp id=%0d last=%b", n1,
                   row_id_out[1], row_last[1], (n1 < 4) ? id1[n1] : -1, (n1 < 4) ? ls1[n1] : 1'b0);
        end
        n1++;
      end
    end
    slot_valid = '0; tick();
    checks++;
    if (n0 != 3 || n1 != 4 || done !== 1'b1) begin
      failures++;
      $display("FAIL basic_done got beats=%0d/%0d done=%b exp beats=3/4 done=1", n0, n1, done);
    end
  endtask

  task automatic test_all_channels();
    drive_idle(); start = 1; num_rows = 20; tick(); start = 0;
    slot_valid = '1;
    for (int c = 0; c < N; c++) row_len_in[c] = 1;
    tick();
    checks++;
    if (row_id_valid !== '1 || row_last !== '1 || row_start !== '1) begin
      failures++;
      $display("FAIL all16_flags got v=%h l=%h s=%h exp ffff", row_id_valid, row_last, row_start);
    end
    for (int c = 0; c < N; c++) begin
      checks++;
      if (row_id_out[c] !== W'(c)) begin
        failures++;
        $display("FAIL all16_id ch=%0d got %0d exp %0d", c, row_id_out[c], c);
      end
    end
    slot_valid = '0; slot_valid[0] = 1'b1; row_len_in[0] = 1;
    tick();
    checks++;
    if (row_id_valid[0] !== 1'b1 || row_id_out[0] !== W'(16)) begin
      failures++;
      $display("FAIL all16_next got v=%b id=%0d exp v=1 id=16", row_id_valid[0], row_id_out[0]);
    end
  endtask

  task automatic test_stall();
    bit stl [7] = '{0, 0, 1, 1, 1, 0, 0};
    int beat = 0;
    drive_idle(); start = 1; num_rows = 1; tick(); start = 0;
    slot_valid = '0; slot_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      stall = stl[cyc];
      row_len_in[0] = (cyc == 0) ? 4 : $urandom;
      tick();
      if (!stl[cyc]) beat++;
      checks++;
      if (row_id_valid[0] !== 1'b1 || row_id_out[0] !== '0 || row_last[0] !== (beat == 4)
          || row_start[0] !== (beat == 1) || row_id_valid[N-1:1] !== '0) begin
        failures++;
        $display("FAIL stall cyc=%0d beat=%0d got v=%b id=%0d l=%b s=%b exp v=1 id=0 l=%b s=%b", cyc, beat,
                 row_id_valid[0], row_id_out[0], row_last[0], row_start[0], beat == 4, beat == 1);
      end
    end
    stall = 0; slot_valid = '0; tick(); tick();
    checks++;
    if (done !== 1'b1 || row_id_valid !== '0) begin
      failures++;
      $display("FAIL stall_done got done=%b v=%h exp done=1 v=0", done, row_id_valid);
    end
  endtask

  task automatic test_overflow();
    drive_idle(); start = 1; num_rows = 1; tick(); start = 0;
    slot_valid = 16'h0003; row_len_in[0] = 1; row_len_in[1] = 1;
    tick();
    checks++;
    if (row_id_valid !== 16'h0001 || row_id_out[0] !== '0 || err !== ERRCHK) begin
      failures++;
      $display("FAIL overflow got v=%h id0=%0d err=%b exp v=0001 id0=0 err=%b",
               row_id_valid, row_id_out[0], err, ERRCHK);
    end
  endtask

  task automatic test_zero_len();
    drive_idle(); start = 1; num_rows = 3; tick(); start = 0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_clear got err=%b exp 0", err);
    end
    slot_valid = 16'h0001; row_len_in[0] = 0;
    tick();
    checks++;
    if (row_id_valid[0] !== 1'b1 || row_start[0] !== 1'b1 || row_last[0] !== 1'b1
        || row_id_out[0] !== '0 || err !== ERRCHK) begin
      failures++;
      $display("FAIL zero_len got v=%b s=%b l=%b id=%0d err=%b exp v=1 s=1 l=1 id=0 err=%b",
               row_id_valid[0], row_start[0], row_last[0], row_id_out[0], err, ERRCHK);
    end
    drive_idle(); start = 1; num_rows = 0; tick(); start = 0;
    tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_rows_done got done=%b exp 1", done);
    end
  endtask

  task automatic test_reset_mid_row();
    drive_idle(); start = 1; num_rows = 5; tick(); start = 0;
    slot_valid = 16'h0001; row_len_in[0] = 3;
    tick(); tick();
    rst = 1; #1;
    checks++;
    if (row_id_valid !== '0 || row_last !== '0 || row_start !== '0 || done !== 1'b0
        || err !== 1'b0 || row_id_out[0] !== '0) begin
      failures++;
      $display("FAIL reset_mid got v=%h l=%h s=%h d=%b e=%b id0=%0d exp all 0",
               row_id_valid, row_last, row_start, done, err, row_id_out[0]);
    end
    model_reset();
    #2 rst = 0;
    drive_idle(); start = 1; num_rows = 2; tick(); start = 0;
    slot_valid = 16'h0003; row_len_in[0] = 1; row_len_in[1] = 1;
    tick();
    checks++;
    if (row_id_valid !== 16'h0003 || row_id_out[0] !== W'(0) || row_id_out[1] !== W'(1)) begin
      failures++;
      $display("FAIL reset_restart got v=%h id0=%0d id1=%0d exp v=0003 id0=0 id1=1",
               row_id_valid, row_id_out[0], row_id_out[1]);
    end
  endtask

  task automatic test_random();
    drive_idle(); start = 1; num_rows = $urandom_range(5, 40); tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = ($urandom_range(0, 29) == 0);
      num_rows = $urandom_range(0, 40);
      stall = ($urandom_range(0, 4) == 0);
      slot_valid = N'($urandom);
      for (int c = 0; c < N; c++) row_len_in[c] = $urandom_range(0, 5);
      tick();
      checks++;
      if (row_id_valid !== e_valid || row_last !== e_last || row_start !== e_start
          || done !== m_done || err !== m_err) begin
        failures++;
        $display("FAIL random_flags cyc=%0d got v=%h l=%h s=%h d=%b e=%b exp v=%h l=%h s=%h d=%b e=%b", cyc,
                 row_id_valid, row_last, row_start, done, err, e_valid, e_last, e_start, m_done, m_err);
      end
      for (int c = 0; c < N; c++) begin
        if (e_valid[c]) begin
          checks++;
          if (row_id_out[c] !== e_id[c]) begin
            failures++;
            $display("FAIL random_id cyc=%0d ch=%0d got %0d exp %0d", cyc, c, row_id_out[c], e_id[c]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_channels();
    test_stall();
    test_overflow();
    test_zero_len();
    test_reset_mid_row();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
